// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer:
// record kind encodings, default field widths, record layout.
package trace_pkg;

   localparam int DROP_CNT_W   = 16;
   localparam int TRACE_DATA_W = 32;
   localparam int TRACE_ADDR_W = 9;

   localparam logic [1:0] KIND_REG  = 2'b01;
   localparam logic [1:0] KIND_MEMW = 2'b10;
   localparam logic [1:0] KIND_MEMR = 2'b11;

   // Record layout for the default widths; MSB first.
   typedef struct packed {
      logic [1:0]              kind;
      logic [TRACE_ADDR_W-1:0] tag;
      logic [TRACE_DATA_W-1:0] data;
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo2w.sv
// Dual-write, single-read synchronous FIFO for trace records.
// Ports: clk, rst_n (async, active-low); i_push_cnt (0..2 records),
//        i_wr0/i_wr1 (records, wr0 lands first), i_pop;
//        o_head (record at read pointer), o_level (occupancy 0..DEPTH).
// The caller guarantees i_push_cnt never exceeds DEPTH - o_level.
module trace_fifo2w #(
   parameter  int W     = 43,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    i_push_cnt,
   input  logic [W-1:0]  i_wr0,
   input  logic [W-1:0]  i_wr1,
   input  logic          i_pop,
   output logic [W-1:0]  o_head,
   output logic [LW-1:0] o_level
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [LW-1:0] r_level;

   logic [AW-1:0] w_wp1;
   logic          w_pop;

   // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
   assign w_wp1 = r_wp + AW'(1);
   assign w_pop = i_pop && (r_level != '0);

   // Storage carries no reset; only pointers and level define content.
   always_ff @(posedge clk) begin
      if (i_push_cnt != 2'd0) begin
         r_mem[r_wp] <= i_wr0;
      end
      if (i_push_cnt == 2'd2) begin
         r_mem[w_wp1] <= i_wr1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         r_wp    <= r_wp + AW'(i_push_cnt);
         r_rp    <= r_rp + AW'(w_pop);
         r_level <= r_level + LW'(i_push_cnt) - LW'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rp];
   assign o_level = r_level;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: packs core write-back and data-memory strobes
// into {kind, tag, data} records, buffers them, streams to a host.
// Ports: clk, reset (async, active-low), trace_en;
//        reg_write_sig/reg_num/reg_data (write-back strobe);
//        wr/rd/addr/wr_data/rd_data (data-memory strobe);
//        out_valid/out_ready/out_data (record stream);
//        level (occupancy), overflow (sticky), drop_cnt (saturating),
//        clr_ovf (clears overflow and drop_cnt).
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter  int DATA_W = TRACE_DATA_W,
   parameter  int ADDR_W = TRACE_ADDR_W,
   parameter  int DEPTH  = 16,
   localparam int REC_W  = 2 + ADDR_W + DATA_W,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trace_en,
   input  logic                  reg_write_sig,
   input  logic [4:0]            reg_num,
   input  logic [DATA_W-1:0]     reg_data,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W-1:0]     rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REC_W-1:0]      out_data,
   output logic [LW-1:0]         level,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   input  logic                  clr_ovf
);

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] tag;
      logic [DATA_W-1:0] data;
   } rec_t;

   logic                  w_reg_ev;
   logic                  w_mem_ev;
   logic [1:0]            w_n_ev;
   logic [LW-1:0]         w_free;
   logic [1:0]            w_push;
   logic [1:0]            w_drop;
   rec_t                  w_reg_rec;
   rec_t                  w_mem_rec;
   rec_t                  w_wr0;
   rec_t                  w_wr1;
   logic [REC_W-1:0]      w_head;
   logic [LW-1:0]         w_level;
   logic                  w_pop;
   logic [DROP_CNT_W-1:0] w_cnt_base;
   logic [DROP_CNT_W:0]   w_cnt_sum;

   logic                  r_ovf;
   logic [DROP_CNT_W-1:0] r_cnt;

   // x0 writes are architecturally invisible: filtered, never dropped.
   assign w_reg_ev = trace_en && reg_write_sig && (reg_num != 5'd0);
   assign w_mem_ev = trace_en && (wr || rd);
   assign w_n_ev   = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};

   // A write wins when wr and rd are both strobed.
   always_comb begin
      w_reg_rec      = '0;
      w_reg_rec.kind = KIND_REG;
      w_reg_rec.tag  = ADDR_W'(reg_num);
      w_reg_rec.data = reg_data;
      w_mem_rec      = '0;
      w_mem_rec.kind = wr ? KIND_MEMW : KIND_MEMR;
      w_mem_rec.tag  = addr;
      w_mem_rec.data = wr ? wr_data : rd_data;
   end

   // Slot 0 takes REG when present, so a single free slot goes to REG.
   assign w_wr0 = w_reg_ev ? w_reg_rec : w_mem_rec;
   assign w_wr1 = w_mem_rec;

   // Space comes from the registered level; a same-cycle pop does
   // not free a slot. When short, free is 0 or 1 (n_ev <= 2).
   assign w_free = LW'(DEPTH) - w_level;

   always_comb begin
      w_push = w_n_ev;
      if (w_free < LW'(w_n_ev)) begin
         w_push = w_free[1:0];
      end
   end

   assign w_drop = w_n_ev - w_push;

   assign out_valid = (w_level != '0);
   assign w_pop     = out_valid && out_ready;
   assign out_data  = out_valid ? w_head : '0;
   assign level     = w_level;

   trace_fifo2w #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .i_push_cnt (w_push),
      .i_wr0      (w_wr0),
      .i_wr1      (w_wr1),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_level    (w_level)
   );

   // Clear applies first, then this cycle's drops are added.
   assign w_cnt_base = clr_ovf ? '0 : r_cnt;
   assign w_cnt_sum  = {1'b0, w_cnt_base} + (DROP_CNT_W+1)'(w_drop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_cnt <= w_cnt_sum[DROP_CNT_W] ? '1 : w_cnt_sum[DROP_CNT_W-1:0];
         r_ovf <= (r_ovf && !clr_ovf) || (w_drop != 2'd0);
      end
   end

   assign overflow = r_ovf;
   assign drop_cnt = r_cnt;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Debug/trace stage directly downstream of the riscv core.
- Consumes the core's write-back strobe (reg_write_sig/reg_num/reg_data) and data-memory strobe (wr/rd/addr/wr_data/rd_data).
- Packs each architecturally visible event into a 43-bit record and buffers it in a dual-push FIFO.
- Drains records to a debug host over a valid/ready stream; counts events lost to overflow.

Parameters:
DATA_W, 32, data width of reg/memory payloads
ADDR_W, 9, data-memory address width; also tag field width
DEPTH, 16, FIFO entries; power of two, min 4
REC_W, 2+ADDR_W+DATA_W (43), record width; derived, not overridable

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
trace_en  in  1  1 = capture events; 0 = ignore inputs, draining continues
reg_write_sig  in  1  core register-file write strobe
reg_num  in  5  destination register
reg_data  in  DATA_W  value written
wr  in  1  data-memory write strobe
rd  in  1  data-memory read strobe
addr  in  ADDR_W  data-memory address
wr_data  in  DATA_W  store data
rd_data  in  DATA_W  load data
out_valid  out  1  record available
out_ready  in  1  host accepts record
out_data  out  REC_W  {kind[1:0], tag[ADDR_W-1:0], data[DATA_W-1:0]}
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one event dropped
drop_cnt  out  16  saturating count of dropped events
clr_ovf  in  1  one-cycle pulse: clear overflow and drop_cnt

Behaviour:
- Reset (reset=0, async): pointers, level, drop_cnt = 0; overflow = 0; out_valid = 0. Storage is not reset. Reset mid-stream discards all contents.
- Event qualification, per cycle, only when trace_en=1:
  - REG event: reg_write_sig=1 and reg_num!=0. x0 writes are filtered and are never counted as drops.
  - MEM event: wr=1 or rd=1. If both are asserted, it is a write.
- Record kind: REG=2'b01, MEMW=2'b10, MEMR=2'b11.
- Record tag: REG uses zero-extended reg_num; MEM uses addr.
- Record data: reg_data, wr_data, or rd_data respectively.
- Dual push: 0, 1 or 2 records per cycle. Order is REG first, then MEM, at consecutive write-pointer slots.
- Space check: free = DEPTH - level, using the registered level.
  - A pop in the same cycle does NOT create space for a push.
  - With free=1 and two events, REG is accepted and MEM is dropped. With free=0, both are dropped.
- Drops:
  - drop_cnt += number dropped (0..2), saturating at 16'hFFFF.
  - overflow set to 1 on any drop.
  - On clr_ovf: clear first, then apply this cycle's drops. Example: clr_ovf plus 1 drop gives drop_cnt=1, overflow=1.
- Output stream:
  - out_valid = (level != 0); out_data = storage[rd_ptr] when valid, else all zeros.
  - Pop occurs when out_valid and out_ready are both 1.
  - Record data and order are held stable until accepted.
- Latency: an event captured at edge N into an empty FIFO gives out_valid=1 after edge N. The record is visible in the cycle following the strobe, i.e. one-cycle latency.
- Level update: level_next = level + pushes - pop. Pointers wrap modulo DEPTH. Occupancy level ranges 0..DEPTH.
- trace_en=0 suppresses capture and drop counting only. Pops proceed normally.

Decomposition:
- Package trace_pkg: kind encodings (KIND_REG, KIND_MEMW, KIND_MEMR), trace_rec_t packed struct {kind, tag, data}, DROP_CNT_W=16.
- One sub-module: trace_fifo2w, a dual-write single-read synchronous FIFO.
  - Inputs: push count 0..2, two write records, pop.
  - Outputs: head record, level.
  - Top level holds event qualification, space arbitration and drop counters.

Test Plan:
- REG write x5=0xDEADBEEF into empty FIFO, out_ready=1 -> next cycle out_valid=1, out_data={01,9'd5,0xDEADBEEF}; level returns to 0 after pop. A reg_num=0 write produces nothing.
- Same cycle: REG x3=0x11 plus MEM write addr 0x1F0, data 0x22 -> two records in order: {01,3,0x11} then {10,0x1F0,0x22}; level=2.
- out_ready=0, 16 single REG events -> level=16. A 17th cycle with REG+MEM gives drop_cnt=2, overflow=1, level stays 16.
- level=15 with REG+MEM the same cycle (out_ready=0) -> REG stored, MEM dropped, drop_cnt=1. At full with pop and push the same cycle -> push dropped, level=15.
- wr=1 and rd=1 at addr 0x004 -> single MEMW record carrying wr_data. trace_en=0 with any strobes -> no records, drop_cnt unchanged.
- clr_ovf pulse alongside a drop -> drop_cnt=1, overflow=1. drop_cnt preloaded near saturation stays at 0xFFFF. Async reset assertion mid-drain -> out_valid=0 and level=0 immediately.
